// File: rtl/ad9518_spi_readback.sv
// ----------------------------------------------------------------------------
// ad9518_spi_readback
//   Read-back engine for the AD9518 3-wire SPI port. Sends the 16-bit read
//   instruction {R/W=1, W1:W0=00, ADDR[12:0]} MSB first, releases SDIO after
//   the instruction and shifts in one register byte driven by the device.
//   The pins are shared with the configuration writer at board level; this
//   block assumes it owns the bus while BUSY is high.
//
//   Parameters:
//     CLK_DIV         SCLK half-period in CLK cycles (>= 1), SCLK = CLK/(2*CLK_DIV)
//   Ports:
//     CLK, RST        system clock, synchronous active-high reset
//     RD_EN           one-cycle read request, only looked at while idle
//     RD_ADDR         register address, captured with the accepted RD_EN
//     RD_DATA         last byte read, held until the next completion
//     RD_VALID        one-cycle pulse when RD_DATA is updated
//     BUSY            transaction in progress (setup through gap)
//     AD9518_nCS      chip select, active low
//     AD9518_SCLK     serial clock, idles low
//     AD9518_SDIO_O   SDIO drive value
//     AD9518_SDIO_OE  SDIO output enable (1 = FPGA drives)
//     AD9518_SDIO_I   SDIO pad input
//
//   Every pin and status output is a flop; the combinational process only
//   computes next values, so SCLK and nCS cannot glitch.
// ----------------------------------------------------------------------------
module ad9518_spi_readback #(
    parameter int CLK_DIV = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RD_EN,
    input  logic [12:0] RD_ADDR,
    output logic [7:0]  RD_DATA,
    output logic        RD_VALID,
    output logic        BUSY,
    output logic        AD9518_nCS,
    output logic        AD9518_SCLK,
    output logic        AD9518_SDIO_O,
    output logic        AD9518_SDIO_OE,
    input  logic        AD9518_SDIO_I
);

    localparam int              PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
    localparam logic [4:0]      BIT_LAST = 5'd23;
    localparam logic [4:0]      BIT_TURN = 5'd16;  // first data bit (D7)
    localparam logic [4:0]      BIT_INST = 5'd15;  // last instruction bit

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [4:0]      bit_q, bit_d;
    logic [14:0]     tx_q, tx_d;      // instruction bits 14..0 still to send
    logic [7:0]      rx_q, rx_d;
    logic            ncs_q, ncs_d;
    logic            sclk_q, sclk_d;  // also tells low/high half of the bit
    logic            sdo_q, sdo_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ph_last;

    assign ph_last = (ph_q == PH_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        data_d  = data_q;
        valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (RD_EN) begin
                    state_d = S_SETUP;
                    ph_d    = '0;
                    bit_d   = '0;
                    tx_d    = {2'b00, RD_ADDR};
                    sdo_d   = 1'b1;          // R/W bit, held through setup
                    oe_d    = 1'b1;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_SETUP: begin
                if (ph_last) begin
                    state_d = S_SHIFT;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_ONE;
                end
            end

            S_SHIFT: begin
                if (!ph_last) begin
                    ph_d = ph_q + PH_ONE;
                end else if (!sclk_q) begin
                    // end of low half: rising edge
                    ph_d   = '0;
                    sclk_d = 1'b1;
                end else begin
                    // last cycle of high half: sample, then falling edge
                    ph_d   = '0;
                    sclk_d = 1'b0;
                    if (bit_q >= BIT_TURN)
                        rx_d = {rx_q[6:0], AD9518_SDIO_I};
                    if (bit_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q + 5'd1;
                        if (bit_q == BIT_INST) begin
                            // turnaround: device owns SDIO from bit 16 on
                            sdo_d = 1'b0;
                            oe_d  = 1'b0;
                        end else if (bit_q < BIT_INST) begin
                            sdo_d = tx_q[14];
                            tx_d  = {tx_q[13:0], 1'b0};
                        end
                    end
                end
            end

            S_HOLD: begin
                if (ph_last) begin
                    state_d = S_GAP;
                    ph_d    = '0;
                    ncs_d   = 1'b1;
                    data_d  = rx_q;
                    valid_d = 1'b1;
                end else begin
                    ph_d = ph_q + PH_ONE;
                end
            end

            S_GAP: begin
                if (ph_last) begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                    busy_d  = 1'b0;
                end else begin
                    ph_d = ph_q + PH_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign RD_DATA        = data_q;
    assign RD_VALID       = valid_q;
    assign BUSY           = busy_q;
    assign AD9518_nCS     = ncs_q;
    assign AD9518_SCLK    = sclk_q;
    assign AD9518_SDIO_O  = sdo_q;
    assign AD9518_SDIO_OE = oe_q;

endmodule

// File: tb/tb_ad9518_spi_readback.sv
// ----------------------------------------------------------------------------
// tb_ad9518_spi_readback
//   Two instances (CLK_DIV=4 and CLK_DIV=1) share a clock. A behavioural
//   AD9518 slave watches each bus: it collects the instruction on SCLK rising
//   edges and returns a byte MSB first, optionally with random noise on SDIO
//   during low halves. Expected timing comes from the cycle formulas
//   (valid at T0+50D+1, idle at T0+51D+1, etc.).
// ----------------------------------------------------------------------------
module tb_ad9518_spi_readback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       rst;
    logic [1:0]       rd_en;
    logic [1:0][12:0] rd_addr;
    logic [1:0][7:0]  rd_data;
    logic [1:0]       rd_valid, busy, ncs, sclk, sdo, oe, sdi;

    ad9518_spi_readback #(.CLK_DIV(4)) u_dut4 (
        .CLK(clk), .RST(rst[0]), .RD_EN(rd_en[0]), .RD_ADDR(rd_addr[0]),
        .RD_DATA(rd_data[0]), .RD_VALID(rd_valid[0]), .BUSY(busy[0]),
        .AD9518_nCS(ncs[0]), .AD9518_SCLK(sclk[0]), .AD9518_SDIO_O(sdo[0]),
        .AD9518_SDIO_OE(oe[0]), .AD9518_SDIO_I(sdi[0])
    );

    ad9518_spi_readback #(.CLK_DIV(1)) u_dut1 (
        .CLK(clk), .RST(rst[1]), .RD_EN(rd_en[1]), .RD_ADDR(rd_addr[1]),
        .RD_DATA(rd_data[1]), .RD_VALID(rd_valid[1]), .BUSY(busy[1]),
        .AD9518_nCS(ncs[1]), .AD9518_SCLK(sclk[1]), .AD9518_SDIO_O(sdo[1]),
        .AD9518_SDIO_OE(oe[1]), .AD9518_SDIO_I(sdi[1])
    );

    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // slave / monitor state, written only by the monitor process
    int          nrise[2], oe_err[2], vcount[2], vcyc[2], vcyc_prev[2];
    int          nfall[2], ncs_up[2], brise[2], bfall[2];
    logic [15:0] icap[2];
    logic [7:0]  vdata[2], vdata_prev[2];
    logic [1:0]  p_ncs, p_sclk, p_busy;
    // written only by the stimulus process
    logic [7:0]  sdata[2];
    logic [1:0]  glitch;

    initial begin
        p_ncs  = 2'b11;
        p_sclk = 2'b00;
        p_busy = 2'b00;
        sdi    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            nrise[i] = 0; oe_err[i] = 0; vcount[i] = 0; vcyc[i] = 0; vcyc_prev[i] = 0;
            nfall[i] = 0; ncs_up[i] = 0; brise[i] = 0; bfall[i] = 0;
            icap[i] = '0; vdata[i] = '0; vdata_prev[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (p_ncs[i] && !ncs[i]) begin
                    nfall[i] = cyc; nrise[i] = 0; icap[i] = '0; oe_err[i] = 0;
                end
                if (!p_ncs[i] && ncs[i]) ncs_up[i] = cyc;
                if (!p_busy[i] && busy[i]) brise[i] = cyc;
                if (p_busy[i] && !busy[i]) bfall[i] = cyc;
                if (rd_valid[i]) begin
                    vcount[i]++;
                    vcyc_prev[i] = vcyc[i]; vcyc[i] = cyc;
                    vdata_prev[i] = vdata[i]; vdata[i] = rd_data[i];
                end
                if (!ncs[i] && sclk[i] && !p_sclk[i]) begin
                    if (nrise[i] < 16) begin
                        icap[i] = {icap[i][14:0], sdo[i]};
                        if (!oe[i]) oe_err[i]++;
                    end else if (oe[i]) begin
                        oe_err[i]++;
                    end
                    nrise[i]++;
                end
                // device output: bit k of the frame is data bit 23-k
                if (ncs[i])
                    sdi[i] = 1'b0;
                else if (sclk[i])
                    sdi[i] = (nrise[i] >= 17 && nrise[i] <= 24) ? sdata[i][24 - nrise[i]] : 1'b0;
                else if (glitch[i])
                    sdi[i] = 1'($urandom_range(0, 1));
                else
                    sdi[i] = (nrise[i] >= 16 && nrise[i] < 24) ? sdata[i][23 - nrise[i]] : 1'b0;
                p_ncs[i]  = ncs[i];
                p_sclk[i] = sclk[i];
                p_busy[i] = busy[i];
            end
        end
    end

    // One read on instance i; noisy adds extra RD_EN pulses while busy.
    task automatic do_read(input int i, input logic [12:0] addr, input logic [7:0] data,
                           input bit glt, input bit noisy);
        int d;
        int t0;
        int v0;
        d = dv(i);
        @(negedge clk);
        sdata[i]   = data;
        glitch[i]  = glt;
        rd_en[i]   = 1'b1;
        rd_addr[i] = addr;
        t0 = cyc;
        v0 = vcount[i];
        for (int c = 1; c < 51 * d + 5; c++) begin
            @(negedge clk);
            if (noisy && (c == 10 || c == (150 * d) / 4)) begin
                rd_en[i]   = 1'b1;
                rd_addr[i] = 13'($urandom);
            end else begin
                rd_en[i]   = 1'b0;
                rd_addr[i] = 13'($urandom);
            end
        end
        rd_en[i] = 1'b0;
        chk("valid_cnt", vcount[i] - v0, 1);
        chk("valid_cyc", vcyc[i] - t0, 50 * d + 1);
        chk("rd_data", vdata[i], data);
        chk("rd_hold", rd_data[i], data);
        chk("instr", icap[i], {3'b100, addr});
        chk("sclk_edges", nrise[i], 24);
        chk("oe_dir", oe_err[i], 0);
        chk("ncs_fall", nfall[i] - t0, 1);
        chk("ncs_rise", ncs_up[i] - t0, 50 * d + 1);
        chk("busy_rise", brise[i] - t0, 1);
        chk("busy_fall", bfall[i] - t0, 51 * d + 1);
        chk("idle_pins", {ncs[i], sclk[i], oe[i], sdo[i], busy[i]}, 5'b10000);
    endtask

    // RST asserted mid-shift at T0+60, new read issued at T0+70.
    task automatic reset_abort(input int i);
        int t0;
        int v0;
        @(negedge clk);
        sdata[i]   = 8'h77;
        glitch[i]  = 1'b0;
        rd_en[i]   = 1'b1;
        rd_addr[i] = 13'h0AAA;
        t0 = cyc;
        v0 = vcount[i];
        repeat (60) begin
            @(negedge clk);
            rd_en[i] = 1'b0;
        end
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
        chk("abort_pins", {ncs[i], sclk[i], oe[i], sdo[i], busy[i], rd_valid[i]}, 6'b100000);
        chk("abort_data", rd_data[i], 8'h00);
        repeat (8) @(negedge clk);
        chk("abort_novalid", vcount[i] - v0, 0);
        chk("abort_t", cyc - t0, 69);
        do_read(i, 13'h0042, 8'h3C, 1'b0, 1'b0);
    endtask

    // RD_EN held high across two reads.
    task automatic back_to_back(input int i);
        int d;
        int t0;
        int v0;
        d = dv(i);
        @(negedge clk);
        sdata[i]   = 8'h12;
        glitch[i]  = 1'b0;
        rd_en[i]   = 1'b1;
        rd_addr[i] = 13'h0010;
        t0 = cyc;
        v0 = vcount[i];
        repeat (51 * d) @(negedge clk);
        sdata[i]   = 8'h34;
        rd_addr[i] = 13'h0011;
        repeat (2) @(negedge clk);
        rd_en[i] = 1'b0;
        repeat (50 * d + 4) @(negedge clk);
        chk("b2b_cnt", vcount[i] - v0, 2);
        chk("b2b_data1", vdata_prev[i], 8'h12);
        chk("b2b_data2", vdata[i], 8'h34);
        chk("b2b_vcyc1", vcyc_prev[i] - t0, 50 * d + 1);
        chk("b2b_vcyc2", vcyc[i] - t0, 101 * d + 2);
        chk("b2b_nfall2", nfall[i] - t0, 51 * d + 2);
        chk("b2b_gap", (nfall[i] - vcyc_prev[i]) >= d, 1'b1);
        chk("b2b_instr2", icap[i], 16'h8011);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 2'b11;
        rd_en      = 2'b00;
        rd_addr[0] = '0;
        rd_addr[1] = '0;
        glitch     = 2'b00;
        sdata[0]   = '0;
        sdata[1]   = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_pins", {ncs[i], sclk[i], sdo[i], oe[i], busy[i], rd_valid[i]}, 6'b100000);
            chk("reset_data", rd_data[i], 8'h00);
        end
        rst = 2'b00;

        do_read(0, 13'h0003, 8'hA5, 1'b0, 1'b0);
        do_read(1, 13'h1FFF, 8'h00, 1'b0, 1'b0);
        do_read(0, 13'h0155, 8'h5A, 1'b0, 1'b1);
        do_read(1, 13'h0AAA, 8'hC3, 1'b0, 1'b1);
        reset_abort(0);
        back_to_back(0);
        back_to_back(1);
        for (int i = 0; i < 2; i++) begin
            do_read(i, 13'h0F0F, 8'h96, 1'b1, 1'b0);
            do_read(i, 13'h1234, 8'h69, 1'b1, 1'b0);
        end
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 2; i++) begin
                do_read(i, 13'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
